// File: rtl/mod12_dnc_pkg.sv
// Shared types and helpers for the loadable MOD-N down counter.
package mod12_dnc_pkg;

  localparam int unsigned DEF_MOD = 12;
  localparam int unsigned DEF_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Clamp a load value into the legal count range 0..modv-1.
  function automatic int unsigned sat(input int unsigned v, input int unsigned modv);
    return (v > modv - 1) ? modv - 1 : v;
  endfunction

endpackage

// File: rtl/mod12_dnc_prescaler.sv
// Enabled-cycle prescaler: asserts step on every PRESCALE-th enabled cycle.
module mod12_dnc_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic step_o
);

  localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // step is not masked by clr so a load on a terminal cycle still shows tc.
  assign step_o = en_i & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = step_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mod12_syndnc.sv
// Loadable MOD-N synchronous down counter with cascade borrow (tc) and one-shot stop.
// Define MOD12_DNC_PRESCALE_EN to divide count steps by PRESCALE enabled cycles.
module mod12_syndnc
  import mod12_dnc_pkg::*;
#(
  parameter int unsigned MOD      = DEF_MOD,
  parameter int unsigned W        = DEF_W,
  parameter int unsigned PRESCALE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] in_i,
  input  logic         en_i,
  input  logic         oneshot_i,
  output logic [W-1:0] out_o,
  output logic         tc_o,
  output logic         done_o,
  output logic         running_o
);

  localparam logic [W-1:0] MAXV = W'(MOD - 1);

  if (MOD < 2 || W > 31 || MOD > (32'd1 << W) || PRESCALE < 2) begin : g_param_chk
    $error("mod12_syndnc: illegal MOD/W/PRESCALE combination");
  end

  state_e       state_q, state_d;
  logic [W-1:0] out_q, out_d;
  logic         done_q, done_d, running_q, running_d;
  logic         step, in_run, at_zero;

  assign in_run  = (state_q == RUN);
  assign at_zero = (out_q == '0);

`ifdef MOD12_DNC_PRESCALE_EN
  mod12_dnc_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (load_i | ~in_run),
    .en_i   (en_i & in_run),
    .step_o (step)
  );
`else
  assign step = en_i;
`endif

  assign tc_o = in_run & step & at_zero;

  // Next-state logic: load wins over any count event.
  always_comb begin
    state_d = state_q;
    if (load_i)                                     state_d = RUN;
    else if (in_run && step && at_zero && oneshot_i) state_d = DONE;
  end

  always_comb begin
    out_d = out_q;
    if (load_i)                out_d = W'(sat(32'(in_i), MOD));
    else if (in_run && step) begin
      if (!at_zero)            out_d = out_q - W'(1);
      else if (!oneshot_i)     out_d = MAXV;
    end
  end

  // Flag outputs are registered alongside the state they describe.
  always_comb begin
    done_d    = (state_d == DONE);
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      out_q     <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign out_o     = out_q;
  assign done_o    = done_q;
  assign running_o = running_q;

endmodule

// File: doc/mod12_syndnc.md
Name: mod12_syndnc

Overview:
- Loadable MOD-N synchronous down counter, default MOD-12. Counterpart to the team's MOD-12 loadable up counter.
- Counts MOD-1 → 0 and then either wraps back to MOD-1 or stops, depending on the `oneshot` input.
- Provides a cascade borrow output (`tc`) so stages can be chained into multi-digit down counters and countdown timers.
- A small FSM gates counting so that nothing counts until the first load after reset.

Parameters:
- MOD, 12, counter modulus; count range 0..MOD-1; legal range 2 ≤ MOD ≤ 2**W.
- W, 4, counter and load width in bits.
- PRESCALE, 4, enabled cycles per count step; used only when MOD12_DNC_PRESCALE_EN is defined; legal range ≥ 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  synchronous load strobe.
- in  input  W  load value.
- en  input  1  count enable; cascade input, driven by the previous stage's `tc`.
- oneshot  input  1  1 = stop at 0; 0 = wrap to MOD-1.
- out  output  W  registered count.
- tc  output  1  combinational borrow/terminal count.
- done  output  1  registered; high while stopped at 0 in one-shot mode.
- running  output  1  registered; high while the FSM is in RUN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out = 0, state = IDLE, done = 0, running = 0.
  - Prescaler count = 0.
  - Release is synchronous to clk.
- FSM states: IDLE, RUN, DONE. Encoding is defined in the package.
- Per-edge priority, highest first: load > count > hold.
- Load:
  - Any state with load = 1 → out = sat(in), state = RUN.
  - sat(in) = in if in ≤ MOD-1, else MOD-1. Out-of-range values are never stored.
  - Load also clears done and the prescaler.
- IDLE:
  - out holds; en is ignored; tc = 0.
  - Leaves IDLE only via load.
- RUN, when a step occurs (step = en without the macro; see Optional Feature):
  - out > 0 → out - 1.
  - out == 0 and oneshot = 0 → out = MOD-1, stay in RUN.
  - out == 0 and oneshot = 1 → out stays 0, state = DONE, done = 1 on the next cycle.
- DONE:
  - out holds 0; done = 1; tc = 0; en is ignored.
  - Exits only via load or reset.
- tc = (state == RUN) & step & (out == 0).
  - Combinational and glitch-tolerant for synchronous cascading.
  - A cascaded stage decrements on the same edge the lower stage wraps.
- running = (state == RUN), registered with the state.
- Latency:
  - load → out valid 1 cycle.
  - Step → out updates on the same edge.
  - done asserts 1 cycle after the terminal step.
- Changing oneshot mid-count takes effect at the next zero crossing.
- Reset asserted mid-count: immediate return to the reset values above, with no wait for a clock edge.

Optional Feature:
- Macro MOD12_DNC_PRESCALE_EN.
- Defined:
  - An internal prescaler counts enabled cycles in RUN, 0..PRESCALE-1.
  - step = en & (prescaler == PRESCALE-1); the prescaler wraps to 0 on each step.
  - The prescaler is cleared on load, on reset, and while in IDLE/DONE.
  - tc uses this step, so downstream stages see one borrow per PRESCALE·MOD enabled cycles.
- Undefined: step = en; no prescaler logic or storage is present.

Decomposition:
- Package mod12_dnc_pkg contains:
  - state typedef: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - Default MOD and W constants.
  - The sat() function.
- Sub-module mod12_dnc_prescaler, instantiated only under MOD12_DNC_PRESCALE_EN.
  - Inputs: clk, rst_n, clr, en.
  - Output: step.

Test Plan:
- Reset, then en = 1 with no load for 20 cycles → out = 0, running = 0, tc never asserts.
- load in = 5, oneshot = 0, en = 1 → out sequence 5,4,3,2,1,0,11,10…; tc = 1 only on the cycle out = 0; running = 1.
- load in = 14 (out of range) → out = 11 after 1 cycle; next step gives 10.
- oneshot = 1, load in = 2, en = 1 → out 2,1,0,0…; done = 1 starting the cycle after the 0-step; tc pulses once; a later load in = 3 clears done and gives out = 3.
- Simultaneous load = 1, in = 7 with en = 1 at out = 0 → out = 7, no wrap to 11; tc is still combinationally high during that cycle.
- Reset pulsed asynchronously mid-count at out = 6 → out = 0 immediately, state = IDLE. With MOD12_DNC_PRESCALE_EN and PRESCALE = 4: load 3, en = 1 → out decrements every 4th cycle.
